if1_fetch_align: RTL and testbench

Second fetch stage, parametrised successor of the fixed 4-wide stage-1 fetch block. It accepts one fetch request per handshake from IF0 and waits for the matching I-cache line. It extracts the instructions from the PC's slot up to the line end, or up to the first predicted-taken jump, and pushes them as one group into the instruction buffer. Groups that cannot be pushed are held in a multi-entry skid FIFO. Responses belonging to requests killed by a flush are discarded.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/if1_group_fifo.sv | 61 ++++++
 rtl/if1_fetch_align.sv | 162 ++++++++++++++++
 tb/tb_if1_fetch_align.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the IF1 fetch-align stage: FSM encoding,
// per-instruction IB lane record and default parameter values.
package fetch_pkg;

  localparam int FETCH_WIDTH_DEF   = 4;
  localparam int SKID_DEPTH_DEF    = 2;
  localparam int IB_WIDTH_LOG2_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // One IB entry, MSB first as the instruction buffer expects it.
  typedef struct packed {
    logic        pc_valid;
    logic        pc_is_jump;
    logic        in_excp;
    logic [5:0]  ecode;
    logic [8:0]  subecode;
    logic [31:0] pc;
    logic [31:0] instr;
  } lane_t;

  localparam int ENTRY_WD_DEF = $bits(lane_t);

endpackage

// File: rtl/if1_group_fifo.sv
// Skid FIFO holding whole fetch groups; pointers wrap modulo DEPTH and a
// count register tells full from empty.
module if1_group_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/if1_fetch_align.sv
// IF1: waits for the I-cache line of the accepted IF0 request, extracts the
// group from the PC slot up to line end or first predicted-taken jump, pushes it.
module if1_fetch_align
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH   = FETCH_WIDTH_DEF,
  parameter int SKID_DEPTH    = SKID_DEPTH_DEF,
  parameter int IB_WIDTH_LOG2 = IB_WIDTH_LOG2_DEF,
  parameter int ENTRY_WD      = ENTRY_WD_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_IF,
  input  logic                                if0_valid,
  output logic                                if1_ready,
  input  logic [48+2*FETCH_WIDTH-1:0]         if0_if1_bus,
  input  logic                                data_ok,
  input  logic [32*FETCH_WIDTH-1:0]           rdata,
  input  logic [IB_WIDTH_LOG2:0]              can_push_size,
  output logic [$clog2(FETCH_WIDTH):0]        push_num,
  output logic [FETCH_WIDTH*ENTRY_WD-1:0]     if1_to_ib,
  output state_t                              dbg_state,
  output logic [$clog2(SKID_DEPTH+1)-1:0]     dbg_fifo_count
);

  localparam int FW      = FETCH_WIDTH;
  localparam int OFFW    = $clog2(FW);
  localparam int NW      = OFFW + 1;
  localparam int BUS_WD  = 48 + 2 * FW;
  localparam int CW      = IB_WIDTH_LOG2 + 1;
  localparam int CMPW    = (NW > CW) ? NW : CW;
  localparam int LANES_W = FW * ENTRY_WD;
  localparam int GRP_W   = NW + LANES_W;

  // Handshake: a request transfers on the cycle where if0_valid && if1_ready;
  // if1_ready never depends on if0_valid. A push of push_num entries is
  // unconditional: it is only raised when can_push_size already covers it.

  state_t              state, state_nxt;
  logic [BUS_WD-1:0]   req_q;
  logic [BUS_WD-1:0]   src;
  logic                src_excp;
  logic [5:0]          src_ecode;
  logic [8:0]          src_subecode;
  logic [FW-1:0]       src_valid;
  logic [FW-1:0]       src_jump;
  logic [31:0]         src_pc;
  logic [OFFW-1:0]     off;
  logic                found;
  int                  jslot;
  lane_t               lane_tmp;
  logic [NW-1:0]       ext_n;
  logic [LANES_W-1:0]  ext_lanes;
  logic [GRP_W-1:0]    fifo_head;
  logic [NW-1:0]       head_n;
  logic                fifo_full, fifo_empty;
  logic                fifo_push, pop, bypass, resp, accept;

  // In IDLE the live bus feeds extraction (exception groups), otherwise req_q.
  assign src          = (state == ST_IDLE) ? if0_if1_bus : req_q;
  assign src_excp     = src[BUS_WD-1];
  assign src_ecode    = src[BUS_WD-2 -: 6];
  assign src_subecode = src[BUS_WD-8 -: 9];
  assign src_valid    = src[32+FW +: FW];
  assign src_jump     = src[32 +: FW];
  assign src_pc       = src[31:0];

  always_comb begin
    off       = src_pc[OFFW+1:2];
    found     = 1'b0;
    jslot     = 0;
    lane_tmp  = '0;
    ext_lanes = '0;
    for (int s = 0; s < FW; s++) begin
      if (!found && s >= int'(off) && src_jump[s] && src_valid[s]) begin
        found = 1'b1;
        jslot = s;
      end
    end
    if (src_excp)   ext_n = NW'(1);
    else if (found) ext_n = NW'(jslot - int'(off) + 1);
    else            ext_n = NW'(FW - int'(off));
    for (int k = 0; k < FW; k++) begin
      int s;
      s = (int'(off) + k) % FW;
      lane_tmp.pc_valid   = src_valid[s];
      lane_tmp.pc_is_jump = src_jump[s];
      lane_tmp.in_excp    = src_excp;
      lane_tmp.ecode      = src_ecode;
      lane_tmp.subecode   = src_subecode;
      lane_tmp.pc         = src_pc + 32'(4 * k);
      lane_tmp.instr      = src_excp ? 32'h0 : rdata[32*s +: 32];
      ext_lanes[k*ENTRY_WD +: ENTRY_WD] = ENTRY_WD'(lane_tmp);
    end
  end

  if1_group_fifo #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (GRP_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush_IF),
    .push      (fifo_push),
    .push_data ({ext_n, ext_lanes}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (dbg_fifo_count)
  );

  assign head_n = fifo_head[GRP_W-1 -: NW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !flush_IF && !src_excp) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (data_ok)       state_nxt = ST_IDLE;
        else if (flush_IF) state_nxt = ST_DROP;
      end
      ST_DROP: if (data_ok) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Head has priority; bypass is only possible with an empty FIFO anyway.
  always_comb begin
    pop       = !flush_IF && !fifo_empty &&
                (CMPW'(head_n) <= CMPW'(can_push_size));
    if1_ready = (state == ST_IDLE) && (!fifo_full || pop);
    accept    = if0_valid && if1_ready;
    resp      = (state == ST_WAIT) && data_ok && !flush_IF;
    bypass    = resp && fifo_empty && (CMPW'(ext_n) <= CMPW'(can_push_size));
    fifo_push = (resp && !bypass) ||
                ((state == ST_IDLE) && accept && src_excp && !flush_IF);
    push_num  = '0;
    if1_to_ib = '0;
    if (pop) begin
      push_num  = head_n;
      if1_to_ib = fifo_head[LANES_W-1:0];
    end else if (bypass) begin
      push_num  = ext_n;
      if1_to_ib = ext_lanes;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else if ((state == ST_IDLE) && accept && !flush_IF && !src_excp)
      req_q <= if0_if1_bus;
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_if1_fetch_align.sv
// Directed plus randomized bench for if1_fetch_align (FW=4, skid depth 2)
// with a slot-walking reference model and an expected-lane scoreboard.
module tb_if1_fetch_align;
  import fetch_pkg::*;

  localparam int FW = 4;
  localparam int EW = 82;
  localparam int BW = 56;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush_IF = 1'b0;
  logic           if0_valid = 1'b0;
  logic [BW-1:0]  bus = '0;
  logic           data_ok = 1'b0;
  logic [127:0]   rdata = '0;
  logic [4:0]     cps = 5'd8;
  logic           if1_ready;
  logic [2:0]     push_num;
  logic [FW*EW-1:0] if1_to_ib;
  state_t         dbg_state;
  logic [1:0]     dbg_fifo_count;

  logic [EW-1:0]  exp_q[$];
  logic [2:0]     exp_n_q[$];
  int             tests = 0;
  int             fails = 0;

  if1_fetch_align #(
    .FETCH_WIDTH(4), .SKID_DEPTH(2), .IB_WIDTH_LOG2(4), .ENTRY_WD(82)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_IF       (flush_IF),
    .if0_valid      (if0_valid),
    .if1_ready      (if1_ready),
    .if0_if1_bus    (bus),
    .data_ok        (data_ok),
    .rdata          (rdata),
    .can_push_size  (cps),
    .push_num       (push_num),
    .if1_to_ib      (if1_to_ib),
    .dbg_state      (dbg_state),
    .dbg_fifo_count (dbg_fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_bus(input logic excp, input logic [5:0] ec,
      input logic [8:0] sc, input logic [3:0] v, input logic [3:0] jm, input logic [31:0] pc);
    return {excp, ec, sc, v, jm, pc};
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: walk slots from the PC's slot, stop after a valid jump or at line end.
  task automatic expect_group(input logic [BW-1:0] b, input logic [127:0] line);
    logic excp;
    logic [5:0] ec;
    logic [8:0] sc;
    logic [3:0] v, jm;
    logic [31:0] pc;
    int off, cnt;
    {excp, ec, sc, v, jm, pc} = b;
    off = int'((pc >> 2) % 32'd4);
    if (excp) begin
      exp_q.push_back({v[off], jm[off], 1'b1, ec, sc, pc, 32'h0});
      exp_n_q.push_back(3'd1);
    end else begin
      cnt = 0;
      for (int s = off; s < FW; s++) begin
        exp_q.push_back({v[s], jm[s], 1'b0, ec, sc, pc + 32'(4 * cnt), line[32*s +: 32]});
        cnt++;
        if (v[s] && jm[s]) break;
      end
      exp_n_q.push_back(3'(cnt));
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // Scoreboard on whatever is pushed this cycle, then advance to edge+1.
  task automatic tick();
    int n;
    logic [EW-1:0] lane;
    if (push_num != 3'd0) begin
      if (exp_n_q.size() == 0) begin
        check("unexpected_push", push_num, 0);
      end else begin
        n = int'(exp_n_q.pop_front());
        check("grp_n", push_num, n);
        for (int k = 0; k < n; k++) begin
          lane = exp_q.pop_front();
          if (k < int'(push_num)) check("lane", if1_to_ib[k*EW +: EW], lane);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [BW-1:0] b);
    if0_valid = 1'b1;
    bus = b;
    settle();
    check("acc_ready", if1_ready, 1);
    check("acc_nopush", push_num, 0);
    tick();
    if0_valid = 1'b0;
  endtask

  task automatic end_cycle();
    tick();
    data_ok = 1'b0;
    flush_IF = 1'b0;
    if0_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] line, line_b;
    logic [BW-1:0] b;
    logic got;
    int d;

    // Reset state
    #2;
    check("rst_ready", if1_ready, 1);
    check("rst_push_num", push_num, 0);
    check("rst_to_ib", if1_to_ib, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Aligned line, bypass push
    cps = 5'd8;
    line = rand_line();
    b = mk_bus(0, 6'h0, 9'h0, 4'hF, 4'h0, 32'h1C00_0000);
    send_req(b);
    expect_group(b, line);
    data_ok = 1'b1; rdata = line; settle();
    check("aligned_n", push_num, 4);
    check("aligned_pc0", if1_to_ib[0*EW+32 +: 32], 32'h1C00_0000);
    check("aligned_pc3", if1_to_ib[3*EW+32 +: 32], 32'h1C00_000C);
    check("aligned_instr3", if1_to_ib[3*EW +: 32], line[127:96]);
    end_cycle();

    // Offset and jump
    line = rand_line();
    b = mk_bus(0, 6'h0, 9'h0, 4'hF, 4'b0100, 32'h1C00_0004);
    send_req(b);
    expect_group(b, line);
    data_ok = 1'b1; rdata = line; settle();
    check("jump_n", push_num, 2);
    check("jump_pc1", if1_to_ib[1*EW+32 +: 32], 32'h1C00_0008);
    check("jump_instr1", if1_to_ib[1*EW +: 32], line[95:64]);
    end_cycle();

    // Backpressure
    cps = 5'd1;
    line = rand_line();
    b = mk_bus(0, 6'h0, 9'h0, 4'hF, 4'h0, 32'h1C00_0010);
    send_req(b);
    expect_group(b, line);
    data_ok = 1'b1; rdata = line; settle();
    check("bp_hold", push_num, 0);
    end_cycle();
    line_b = rand_line();
    b = mk_bus(0, 6'h0, 9'h0, 4'hF, 4'h0, 32'h1C00_0020);
    send_req(b);
    expect_group(b, line_b);
    data_ok = 1'b1; rdata = line_b; settle();
    check("bp_hold2", push_num, 0);
    end_cycle();
    settle();
    check("bp_full_ready", if1_ready, 0);
    tick();
    cps = 5'd4; settle();
    check("bp_drain", push_num, 4);
    check("bp_ready_pop", if1_ready, 1);
    tick();
    settle();
    check("bp_drain2", push_num, 4);
    tick();
    check("bp_sb_empty", exp_n_q.size(), 0);

    // Exception request: one entry via the FIFO, no data_ok
    cps = 5'd8;
    b = mk_bus(1, 6'h08, 9'h003, 4'hF, 4'h0, 32'h1C00_0024);
    expect_group(b, 128'h0);
    send_req(b);
    settle();
    check("excp_n", push_num, 1);
    check("excp_lane", if1_to_ib[0 +: EW], {1'b1, 1'b0, 1'b1, 6'h08, 9'h003, 32'h1C00_0024, 32'h0});
    check("excp_state", dbg_state, ST_IDLE);
    tick();

    // Flush in WAIT: response three cycles later is dropped
    b = mk_bus(0, 6'h0, 9'h0, 4'hF, 4'h0, 32'h1C00_0040);
    send_req(b);
    flush_IF = 1'b1; settle();
    check("flush_nopush", push_num, 0);
    end_cycle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("drop_ready", if1_ready, 0);
      check("drop_state", dbg_state, ST_DROP);
      tick();
    end
    data_ok = 1'b1; rdata = rand_line(); settle();
    check("drop_resp_nopush", push_num, 0);
    check("drop_resp_ready", if1_ready, 0);
    end_cycle();
    settle();
    check("drop_done_ready", if1_ready, 1);
    tick();

    // Flush together with data_ok: discarded, back to IDLE, no drop armed
    send_req(mk_bus(0, 6'h0, 9'h0, 4'hF, 4'h0, 32'h1C00_0050));
    data_ok = 1'b1; flush_IF = 1'b1; rdata = rand_line(); settle();
    check("flush_ok_nopush", push_num, 0);
    end_cycle();
    settle();
    check("flush_ok_state", dbg_state, ST_IDLE);
    check("flush_ok_ready", if1_ready, 1);
    tick();

    // Async reset mid-WAIT with a buffered group
    cps = 5'd0;
    send_req(mk_bus(0, 6'h0, 9'h0, 4'hF, 4'h0, 32'h1C00_0060));
    data_ok = 1'b1; rdata = rand_line(); settle();
    end_cycle();
    send_req(mk_bus(0, 6'h0, 9'h0, 4'hF, 4'h0, 32'h1C00_0070));
    settle();
    check("pre_rst_ready", if1_ready, 0);
    check("pre_rst_count", dbg_fifo_count, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_ready", if1_ready, 1);
    check("arst_push_num", push_num, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cps = 5'd8; settle();
    check("post_rst_count", dbg_fifo_count, 0);
    check("post_rst_push", push_num, 0);
    check("post_rst_state", dbg_state, ST_IDLE);
    tick();

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      line = rand_line();
      b = mk_bus($urandom_range(0, 5) == 0, 6'($urandom()), 9'($urandom()),
                 4'($urandom()), 4'($urandom()),
                 ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4))
                                            : ($urandom() & 32'hFFFF_FFFC));
      got = 1'b0;
      for (int w = 0; w < 50 && !got; w++) begin
        cps = 5'($urandom_range(0, 16));
        #1;
        if (if1_ready) begin
          if0_valid = 1'b1;
          bus = b;
          got = 1'b1;
          expect_group(b, line);
        end
        settle();
        tick();
        if0_valid = 1'b0;
      end
      if (!got) check("rand_ready_timeout", got, 1);
      else if (!b[BW-1]) begin
        d = $urandom_range(0, 3);
        for (int i = 0; i < d; i++) begin
          cps = 5'($urandom_range(0, 16));
          settle();
          tick();
        end
        cps = 5'($urandom_range(0, 16));
        data_ok = 1'b1; rdata = line;
        settle();
        tick();
        data_ok = 1'b0;
      end
    end

    // Drain
    cps = 5'd16;
    for (int i = 0; i < 6; i++) begin
      settle();
      tick();
    end
    check("drain_groups", exp_n_q.size(), 0);
    check("drain_lanes", exp_q.size(), 0);
    check("drain_count", dbg_fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
